// File: rtl/rvm_scu_dbg_port.sv
// ============================================================================
// Module  : rvm_scu_dbg_port
// Brief   : Host debug port that halts the core and performs one CSR access
//           through the SCU operand path, with a bounded wait for core_idle.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef RVM_SCU_CSRRW
`define RVM_SCU_CSRRW 4'h1
`endif
`ifndef RVM_SCU_CSRRS
`define RVM_SCU_CSRRS 4'h2
`endif

module rvm_scu_dbg_port #(
    parameter logic [7:0] DBG_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [11:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        dbg_busy,
    input  logic        core_idle,
    output logic        dbg_halt,
    input  logic [3:0]  core_scu_op,
    input  logic [4:0]  core_rs1_addr,
    input  logic [31:0] core_rs1,
    input  logic [31:0] core_imm,
    output logic [3:0]  scu_op,
    output logic [4:0]  scu_rs1_addr,
    output logic [31:0] scu_rs1,
    output logic [31:0] scu_imm,
    input  logic [31:0] scu_wb_val
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HALT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      state_q;
    logic        wr_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        halt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 12'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dbg_req) begin
                        wr_q    <= dbg_wr;
                        addr_q  <= dbg_addr;
                        wdata_q <= dbg_wdata;
                        cnt_q   <= 8'd0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        halt_q  <= 1'b1;
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // core_idle has priority over an expiring timeout
                    if (core_idle) begin
                        state_q <= ST_ACCESS;
                    end else if (cnt_q == DBG_TIMEOUT) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                        ack_q   <= 1'b1;
                        halt_q  <= 1'b0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= scu_wb_val;
                    ack_q   <= 1'b1;
                    halt_q  <= 1'b0;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Reads use CSRRS with a zero mask so the CSR is rewritten with itself
    always_comb begin
        scu_op       = core_scu_op;
        scu_rs1_addr = core_rs1_addr;
        scu_rs1      = core_rs1;
        scu_imm      = core_imm;
        if (state_q == ST_ACCESS) begin
            scu_op       = wr_q ? `RVM_SCU_CSRRW : `RVM_SCU_CSRRS;
            scu_rs1_addr = 5'd0;
            scu_rs1      = wr_q ? wdata_q : 32'd0;
            scu_imm      = {20'd0, addr_q};
        end
    end

    assign dbg_ack   = ack_q;
    assign dbg_rdata = rdata_q;
    assign dbg_err   = err_q;
    assign dbg_busy  = busy_q;
    assign dbg_halt  = halt_q;

endmodule

`default_nettype wire

// File: tb/tb_rvm_scu_dbg_port.sv
// ============================================================================
// Module  : tb_rvm_scu_dbg_port
// Brief   : Directed scoreboard bench for rvm_scu_dbg_port with a small CSR model.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef RVM_SCU_CSRRW
`define RVM_SCU_CSRRW 4'h1
`endif
`ifndef RVM_SCU_CSRRS
`define RVM_SCU_CSRRS 4'h2
`endif

module tb_rvm_scu_dbg_port;

    localparam logic [11:0] C_MSCRATCH = 12'h340;
    localparam logic [11:0] C_MTVEC    = 12'h305;
    localparam logic [3:0]  C_RW       = `RVM_SCU_CSRRW;
    localparam logic [3:0]  C_RS       = `RVM_SCU_CSRRS;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dbg_req, dbg_req_t, dbg_wr, core_idle;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [3:0]  core_scu_op;
    logic [4:0]  core_rs1_addr;
    logic [31:0] core_rs1, core_imm;

    logic        ack0, err0, busy0, halt0, ack1, err1, busy1, halt1;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  op0, op1;
    logic [4:0]  rs1a0, rs1a1;
    logic [31:0] rs10, rs11, imm0, imm1, wb0;
    logic [31:0] wb1 = 32'h600D_0004;

    logic [31:0] mscratch = 32'hCAFE_F00D;
    logic [31:0] mtvec    = 32'h0000_01C0;

    int n_checks = 0;
    int n_errors = 0;
    bit sel = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          halts;
        int          div;
        logic [3:0]  op;
        logic [31:0] imm;
        logic [31:0] rs1;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rvm_scu_dbg_port u_dut (
        .clk(clk), .resetn(resetn), .dbg_req(dbg_req), .dbg_wr(dbg_wr),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(ack0),
        .dbg_rdata(rdata0), .dbg_err(err0), .dbg_busy(busy0),
        .core_idle(core_idle), .dbg_halt(halt0), .core_scu_op(core_scu_op),
        .core_rs1_addr(core_rs1_addr), .core_rs1(core_rs1), .core_imm(core_imm),
        .scu_op(op0), .scu_rs1_addr(rs1a0), .scu_rs1(rs10), .scu_imm(imm0),
        .scu_wb_val(wb0)
    );

    rvm_scu_dbg_port #(.DBG_TIMEOUT(8'd4)) u_dut_to (
        .clk(clk), .resetn(resetn), .dbg_req(dbg_req_t), .dbg_wr(dbg_wr),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(ack1),
        .dbg_rdata(rdata1), .dbg_err(err1), .dbg_busy(busy1),
        .core_idle(core_idle), .dbg_halt(halt1), .core_scu_op(core_scu_op),
        .core_rs1_addr(core_rs1_addr), .core_rs1(core_rs1), .core_imm(core_imm),
        .scu_op(op1), .scu_rs1_addr(rs1a1), .scu_rs1(rs11), .scu_imm(imm1),
        .scu_wb_val(wb1)
    );

    // CSR model: returns the pre-op value, updates at the clock edge
    assign wb0 = (imm0[11:0] == C_MSCRATCH) ? mscratch :
                 (imm0[11:0] == C_MTVEC)    ? mtvec    : 32'd0;

    always @(posedge clk) begin
        if (op0 == C_RW || op0 == C_RS) begin
            if (imm0[11:0] == C_MSCRATCH)
                mscratch <= (op0 == C_RW) ? rs10 : (mscratch | rs10);
            else if (imm0[11:0] == C_MTVEC)
                mtvec <= ((op0 == C_RW) ? rs10 : (mtvec | rs10)) & 32'hFFFF_FFFC;
        end
    end

    wire        s_ack  = sel ? ack1  : ack0;
    wire        s_err  = sel ? err1  : err0;
    wire        s_halt = sel ? halt1 : halt0;
    wire [31:0] s_rd   = sel ? rdata1 : rdata0;
    wire [3:0]  s_op   = sel ? op1   : op0;
    wire [4:0]  s_rs1a = sel ? rs1a1 : rs1a0;
    wire [31:0] s_rs1  = sel ? rs11  : rs10;
    wire [31:0] s_imm  = sel ? imm1  : imm0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] rd, input logic er, input int lat, input int halts,
                        input int div, input logic [3:0] op, input logic [11:0] addr,
                        input logic [31:0] rs1);
        exp_t e;
        e.rdata = rd; e.err = er; e.lat = lat; e.halts = halts; e.div = div;
        e.op = op; e.imm = {20'd0, addr}; e.rs1 = rs1;
        sb.push_back(e);
    endtask

    task automatic issue(input bit s, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata);
        @(posedge clk); #1;
        dbg_wr = wr; dbg_addr = addr; dbg_wdata = wdata;
        if (s) dbg_req_t = 1'b1; else dbg_req = 1'b1;
    endtask

    // Cycle 1 is the cycle the request is presented; counts until dbg_ack
    task automatic run(input bit s, input int idle_at, input bit keep);
        int cyc, halts, div;
        bit got;
        logic [3:0]  op;
        logic [31:0] imm, rs1;
        exp_t e;
        cyc = 1; halts = 0; div = 0; got = 1'b0; op = 4'd0; imm = 32'd0; rs1 = 32'd0;
        sel = s;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == idle_at) core_idle = 1'b1;
            if (s_halt) halts++;
            if (s_op !== core_scu_op || s_imm !== core_imm || s_rs1 !== core_rs1 ||
                s_rs1a !== core_rs1_addr) begin
                div++; op = s_op; imm = s_imm; rs1 = s_rs1;
                chk("issued_rs1_addr", {27'd0, s_rs1a}, 32'd0);
            end
            if (s_ack) got = 1'b1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (!keep) begin dbg_req = 1'b0; dbg_req_t = 1'b0; end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rdata", s_rd, e.rdata);
            chk("err", {31'd0, s_err}, {31'd0, e.err});
            chk("latency", cyc, e.lat);
            chk("halt_cycles", halts, e.halts);
            chk("scu_issue_cycles", div, e.div);
            if (e.div != 0) begin
                chk("scu_op", {28'd0, op}, {28'd0, e.op});
                chk("scu_imm", imm, e.imm);
                chk("scu_rs1", rs1, e.rs1);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; dbg_req = 1'b0; dbg_req_t = 1'b0; dbg_wr = 1'b0;
        dbg_addr = 12'd0; dbg_wdata = 32'd0; core_idle = 1'b1;
        core_scu_op = 4'hA; core_rs1_addr = 5'd7; core_rs1 = 32'h1111_2222;
        core_imm = 32'hDEAD_0000;

        repeat (3) @(posedge clk); #1;
        chk("rst_ack", {31'd0, ack0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_halt", {31'd0, halt0}, 32'd0);
        chk("rst_passthru", {28'd0, op0}, {28'd0, core_scu_op});

        // Read presented in the very first cycle out of reset
        resetn = 1'b1;
        dbg_wr = 1'b0; dbg_addr = C_MSCRATCH; dbg_wdata = 32'h5555_5555; dbg_req = 1'b1;
        push(32'hCAFE_F00D, 1'b0, 4, 2, 1, C_RS, C_MSCRATCH, 32'd0);
        run(1'b0, 0, 1'b0);
        @(posedge clk); #1;
        chk("mscratch_kept", mscratch, 32'hCAFE_F00D);

        // Write returns the old value, then read back
        issue(1'b0, 1'b1, C_MTVEC, 32'h0000_1234);
        push(32'h0000_01C0, 1'b0, 4, 2, 1, C_RW, C_MTVEC, 32'h0000_1234);
        run(1'b0, 0, 1'b0);
        issue(1'b0, 1'b0, C_MTVEC, 32'hFFFF_FFFF);
        push(32'h0000_1234, 1'b0, 4, 2, 1, C_RS, C_MTVEC, 32'd0);
        run(1'b0, 0, 1'b0);

        // Core busy for 10 cycles
        issue(1'b0, 1'b0, C_MSCRATCH, 32'd0);
        core_idle = 1'b0;
        push(32'hCAFE_F00D, 1'b0, 13, 11, 1, C_RS, C_MSCRATCH, 32'd0);
        run(1'b0, 11, 1'b0);

        // Back-to-back reads with dbg_req held; second ack 4 cycles after first
        issue(1'b0, 1'b0, C_MTVEC, 32'd0);
        push(32'h0000_1234, 1'b0, 4, 2, 1, C_RS, C_MTVEC, 32'd0);
        run(1'b0, 0, 1'b1);
        dbg_addr = C_MSCRATCH;
        push(32'hCAFE_F00D, 1'b0, 5, 2, 1, C_RS, C_MSCRATCH, 32'd0);
        run(1'b0, 0, 1'b0);

        // Reset pulsed during HALT aborts without an ack
        issue(1'b0, 1'b1, C_MSCRATCH, 32'hBAD0_BAD0);
        core_idle = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_halt", {31'd0, halt0}, 32'd1);
        resetn = 1'b0; dbg_req = 1'b0;
        #1;
        chk("mid_rst_halt", {31'd0, halt0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_passthru", {28'd0, op0}, {28'd0, core_scu_op});
        @(posedge clk); #1;
        chk("mid_rst_ack", {31'd0, ack0}, 32'd0);
        resetn = 1'b1; core_idle = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_ack", {31'd0, ack0 | busy0}, 32'd0);
        end
        chk("mscratch_untouched", mscratch, 32'hCAFE_F00D);
        issue(1'b0, 1'b0, C_MSCRATCH, 32'd0);
        push(32'hCAFE_F00D, 1'b0, 4, 2, 1, C_RS, C_MSCRATCH, 32'd0);
        run(1'b0, 0, 1'b0);

        // DBG_TIMEOUT=4: core_idle rises as the counter hits the limit
        issue(1'b1, 1'b0, C_MTVEC, 32'd0);
        core_idle = 1'b0;
        push(32'h600D_0004, 1'b0, 8, 6, 1, C_RS, C_MTVEC, 32'd0);
        run(1'b1, 6, 1'b0);

        // DBG_TIMEOUT=4: core never idle
        issue(1'b1, 1'b0, C_MTVEC, 32'd0);
        core_idle = 1'b0;
        push(32'd0, 1'b1, 7, 5, 0, 4'd0, 12'd0, 32'd0);
        run(1'b1, 0, 1'b0);
        core_idle = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rvm_scu_dbg_port.md
RVM_SCU_DBG_PORT -- requirements
Module: rvm_scu_dbg_port

Interface
REQ-001 The block SHALL have parameter DBG_TIMEOUT, default 8'd255, meaning the maximum cycles to wait for core_idle before the access is aborted.
REQ-002 Port clk, input, 1: core level clock; all state SHALL change on its rising edge.
REQ-003 Port resetn, input, 1: reset, asynchronous and active-low.
REQ-004 Port dbg_req, input, 1: host access request; held high until dbg_ack.
REQ-005 Port dbg_wr, input, 1: 1 = CSR write, 0 = CSR read.
REQ-006 Port dbg_addr, input, 12: CSR address.
REQ-007 Port dbg_wdata, input, 32: write data.
REQ-008 Port dbg_ack, output, 1: one-cycle completion pulse.
REQ-009 Port dbg_rdata, output, 32: CSR value returned by the SCU; valid with dbg_ack and held until the next dbg_ack.
REQ-010 Port dbg_err, output, 1: timeout flag; valid with dbg_ack.
REQ-011 Port dbg_busy, output, 1: high in any state other than IDLE.
REQ-012 Port core_idle, input, 1: core is at an instruction boundary and is not issuing an SCU operation.
REQ-013 Port dbg_halt, output, 1: asks the core to stall.
REQ-014 Ports core_scu_op (4), core_rs1_addr (5), core_rs1 (32) and core_imm (32), inputs: the core's SCU operands.
REQ-015 Ports scu_op (4), scu_rs1_addr (5), scu_rs1 (32) and scu_imm (32), outputs: operands driven into the SCU.
REQ-016 Port scu_wb_val, input, 32: SCU read data.

Function
REQ-017 The FSM SHALL have the states IDLE, HALT, ACCESS and RESP.
REQ-018 In IDLE, when dbg_req=1, the block SHALL register dbg_wr, dbg_addr and dbg_wdata, clear the timeout counter and enter HALT.
- Host inputs are not sampled again until the FSM returns to IDLE.
REQ-019 dbg_halt SHALL be 1 in HALT and ACCESS and 0 in all other states.
REQ-020 In HALT with core_idle=1, the FSM SHALL enter ACCESS on the next edge.
REQ-021 In HALT with core_idle=0, the 8-bit counter SHALL increment.
- When the counter equals DBG_TIMEOUT, the FSM SHALL enter RESP with the error flag set.
- No SCU access is made in that case.
REQ-022 If core_idle=1 in the same cycle the counter reaches DBG_TIMEOUT, the access SHALL win: enter ACCESS, error flag clear.
REQ-023 ACCESS SHALL last exactly one cycle.
- scu_op = `RVM_SCU_CSRRW when a write is latched, `RVM_SCU_CSRRS when a read is latched.
- scu_imm = {20'b0, latched addr}.
- scu_rs1 = latched wdata for a write, 32'b0 for a read.
- scu_rs1_addr = 5'b0.
REQ-024 In ACCESS, scu_wb_val SHALL be registered into dbg_rdata at the closing edge, giving the pre-write CSR value in both the read and the write case.
REQ-025 In all states other than ACCESS, scu_op, scu_rs1_addr, scu_rs1 and scu_imm SHALL equal core_scu_op, core_rs1_addr, core_rs1 and core_imm combinationally.
REQ-026 RESP SHALL last one cycle.
- dbg_ack=1 and dbg_err = error flag.
- Next state is IDLE.
- On timeout, dbg_rdata SHALL be 32'b0.
REQ-027 A read SHALL be issued as CSRRS with a zero mask, so the SCU rewrites the CSR with its own value.
- Counters (mcycle, minstret) therefore hold for that cycle instead of incrementing.
- This is accepted behaviour.
REQ-028 Back-to-back requests: with dbg_req still high in the IDLE cycle after RESP, a new access SHALL start; minimum request-to-ack latency is 4 cycles (IDLE→HALT→ACCESS→RESP).
REQ-029 dbg_req falling before dbg_ack is a protocol violation.
- The block SHALL still complete the access and pulse dbg_ack.

Reset
REQ-030 While resetn=0, the FSM SHALL be IDLE and all registered outputs SHALL be 0: dbg_ack, dbg_err, dbg_rdata, dbg_busy, dbg_halt, counter and latched request.
REQ-031 Reset asserted mid-access SHALL abort without dbg_ack.
- SCU outputs revert immediately to core pass-through.
REQ-032 The first request after reset deassertion SHALL be accepted in the first cycle with resetn=1.

Verification
REQ-033 Read: mscratch=32'hCAFE_F00D, core_idle=1, read request to the MSCRATCH address -> dbg_ack on cycle 4, dbg_rdata=32'hCAFE_F00D, dbg_err=0, mscratch unchanged.
REQ-034 Write: write 32'h0000_1234 to MTVEC (reset value 32'h0000_01C0) -> dbg_rdata=32'h0000_01C0; a subsequent read returns 32'h0000_1234 with bits [1:0] cleared.
REQ-035 Stall: core_idle=0 for 10 cycles, then 1 -> dbg_halt high for 11 cycles, scu_op equals core_scu_op until ACCESS, ack on cycle 13, dbg_err=0.
REQ-036 Timeout: DBG_TIMEOUT=4, core_idle held 0 -> dbg_ack with dbg_err=1 and dbg_rdata=0 within 7 cycles, and no SCU op is issued.
REQ-037 Race and reset: core_idle rises on the cycle the counter reaches the limit -> access completes, dbg_err=0. Separately, resetn pulsed low during HALT -> no ack, dbg_halt=0, IDLE.
REQ-038 Back-to-back: dbg_req held high for two reads -> two dbg_ack pulses exactly 4 cycles apart.
